// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage: FSM states, instruction
// field positions and the bundled decoded-control payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned RD_MSB = 25;
  localparam int unsigned RD_LSB = 21;
  localparam int unsigned RS_MSB = 20;
  localparam int unsigned RS_LSB = 16;
  localparam int unsigned RT_MSB = 15;
  localparam int unsigned RT_LSB = 11;
  localparam int unsigned REG_W  = RD_MSB - RD_LSB + 1;

  localparam logic [1:0] RF_D_SEL_MEM = 2'b01;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] rf_d_sel;
    logic [1:0] rd_sel;
    logic       dm_addr_sel;
    logic       dm_we;
    logic       a_sel;
    logic       b_sel;
    logic       rf_we;
    logic       ret_enable;
  } ctrl_t;

endpackage

// File: rtl/id_ex_hazard_unit.sv
// Load-use detector: flags an instruction whose source register is the
// destination of a load currently sitting in the execute register.
module id_ex_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] ex_instr,
  input  logic              ex_valid,
  input  logic              ex_rf_we,
  input  logic [1:0]        ex_rf_d_sel,
  input  logic [DATA_W-1:0] instruction,
  input  logic              in_valid,
  output logic              load_use
);

  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             unused_bits;

  assign ex_rd = ex_instr[RD_MSB:RD_LSB];
  assign rs    = instruction[RS_MSB:RS_LSB];
  assign rt    = instruction[RT_MSB:RT_LSB];

  assign unused_bits = ^{ex_instr[DATA_W-1:RD_MSB+1], ex_instr[RD_LSB-1:0],
                         instruction[DATA_W-1:RS_MSB+1], instruction[RT_LSB-1:0]};

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_valid && ex_rf_we && (ex_rf_d_sel == RF_D_SEL_MEM) &&
                    (ex_rd != '0) && in_valid && ((ex_rd == rs) || (ex_rd == rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FLUSH_DEPTH = 2
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W       = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] INSTRUCTION,
  input  logic [4:0]        ALU_OP,
  input  logic [1:0]        RF_D_SEL,
  input  logic [1:0]        RD_SEL,
  input  logic              DM_ADDR_SEL,
  input  logic              DM_WE,
  input  logic              A_SEL,
  input  logic              B_SEL,
  input  logic              RF_WE,
  input  logic              ret_enable,
  input  logic [DATA_W-1:0] SE_B,
  input  logic [DATA_W-1:0] QT_B,
  input  logic [DATA_W-1:0] SE_PC,
  input  logic              branch_taken,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_instr,
  output logic [DATA_W-1:0] ex_se_b,
  output logic [DATA_W-1:0] ex_qt_b,
  output logic [DATA_W-1:0] ex_se_pc,
  output logic [4:0]        ex_alu_op,
  output logic [1:0]        ex_rf_d_sel,
  output logic [1:0]        ex_rd_sel,
  output logic              ex_dm_addr_sel,
  output logic              ex_dm_we,
  output logic              ex_a_sel,
  output logic              ex_b_sel,
  output logic              ex_rf_we,
  output logic              ex_ret_enable,
  output logic              hazard_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
  output logic [CNT_W-1:0]  perf_issue_cnt
`endif
);

  localparam int unsigned FLUSH_CW = 3;

  state_t              state;
  logic [FLUSH_CW-1:0] flush_left;
  ctrl_t               in_ctrl;
  ctrl_t               ex_ctrl;
  logic                load_use;

  assign in_ctrl = '{alu_op: ALU_OP, rf_d_sel: RF_D_SEL, rd_sel: RD_SEL,
                     dm_addr_sel: DM_ADDR_SEL, dm_we: DM_WE, a_sel: A_SEL,
                     b_sel: B_SEL, rf_we: RF_WE, ret_enable: ret_enable};

  assign ex_alu_op      = ex_ctrl.alu_op;
  assign ex_rf_d_sel    = ex_ctrl.rf_d_sel;
  assign ex_rd_sel      = ex_ctrl.rd_sel;
  assign ex_dm_addr_sel = ex_ctrl.dm_addr_sel;
  assign ex_dm_we       = ex_ctrl.dm_we;
  assign ex_a_sel       = ex_ctrl.a_sel;
  assign ex_b_sel       = ex_ctrl.b_sel;
  assign ex_rf_we       = ex_ctrl.rf_we;
  assign ex_ret_enable  = ex_ctrl.ret_enable;

  id_ex_hazard_unit #(.DATA_W(DATA_W)) u_hazard (
    .ex_instr    (ex_instr),
    .ex_valid    (ex_valid),
    .ex_rf_we    (ex_ctrl.rf_we),
    .ex_rf_d_sel (ex_ctrl.rf_d_sel),
    .instruction (INSTRUCTION),
    .in_valid    (in_valid),
    .load_use    (load_use)
  );

  // In FLUSH the slot is always consumed (and dropped); elsewhere a hazard blocks it.
  assign in_ready     = ex_ready && ((state == FLUSH) || !load_use);
  assign hazard_stall = load_use && ex_ready && !branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= '0;
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      ex_se_b    <= '0;
      ex_qt_b    <= '0;
      ex_se_pc   <= '0;
      ex_ctrl    <= '0;
    end else if (branch_taken) begin
      ex_valid   <= 1'b0;
      flush_left <= FLUSH_CW'(FLUSH_DEPTH - 1);
      state      <= FLUSH;
    end else if (ex_ready) begin
      case (state)
        FLUSH: begin
          ex_valid <= 1'b0;
          if (flush_left == '0) state <= RUN;
          else                  flush_left <= flush_left - FLUSH_CW'(1);
        end
        default: begin
          if (load_use) begin
            ex_valid <= 1'b0;
            state    <= STALL;
          end else begin
            state    <= RUN;
            ex_valid <= in_valid;
            if (in_valid) begin
              ex_instr <= INSTRUCTION;
              ex_se_b  <= SE_B;
              ex_qt_b  <= QT_B;
              ex_se_pc <= SE_PC;
              ex_ctrl  <= in_ctrl;
            end
          end
        end
      endcase
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic squash;
  logic issue;

  assign squash = branch_taken || ((state == FLUSH) && ex_ready);
  assign issue  = !branch_taken && (state != FLUSH) && in_valid && in_ready;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (hazard_stall && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (squash && !(&perf_flush_cnt))       perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (issue && !(&perf_issue_cnt))        perf_issue_cnt <= perf_issue_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (FLUSH_DEPTH=2).
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instr;
  logic [4:0]        alu_op;
  logic [1:0]        rf_d_sel;
  logic [1:0]        rd_sel;
  logic              dm_addr_sel, dm_we, a_sel, b_sel, rf_we, ret_en;
  logic [DATA_W-1:0] se_b, qt_b, se_pc;
  logic              branch_taken;
  logic              ex_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_instr, ex_se_b, ex_qt_b, ex_se_pc;
  logic [4:0]        ex_alu_op;
  logic [1:0]        ex_rf_d_sel, ex_rd_sel;
  logic              ex_dm_addr_sel, ex_dm_we, ex_a_sel, ex_b_sel, ex_rf_we, ex_ret_enable;
  logic              hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [1:0]        perf_stall_cnt, perf_flush_cnt, perf_issue_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W(DATA_W), .FLUSH_DEPTH(2)
`ifdef ID_EX_PERF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .INSTRUCTION(instr), .ALU_OP(alu_op), .RF_D_SEL(rf_d_sel), .RD_SEL(rd_sel),
    .DM_ADDR_SEL(dm_addr_sel), .DM_WE(dm_we), .A_SEL(a_sel), .B_SEL(b_sel),
    .RF_WE(rf_we), .ret_enable(ret_en), .SE_B(se_b), .QT_B(qt_b), .SE_PC(se_pc),
    .branch_taken(branch_taken), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_instr(ex_instr), .ex_se_b(ex_se_b), .ex_qt_b(ex_qt_b), .ex_se_pc(ex_se_pc),
    .ex_alu_op(ex_alu_op), .ex_rf_d_sel(ex_rf_d_sel), .ex_rd_sel(ex_rd_sel),
    .ex_dm_addr_sel(ex_dm_addr_sel), .ex_dm_we(ex_dm_we), .ex_a_sel(ex_a_sel),
    .ex_b_sel(ex_b_sel), .ex_rf_we(ex_rf_we), .ex_ret_enable(ex_ret_enable),
    .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_issue_cnt(perf_issue_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction; inputs change 1ns after a rising edge, then settle.
  task automatic offer(input logic v, input logic [31:0] i, input logic [4:0] op,
                       input logic we, input logic [1:0] dsel);
    in_valid = v; instr = i; alu_op = op; rf_we = we; rf_d_sel = dsel;
    se_b = i ^ 32'h0000_FFFF;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; alu_op = '0; rf_d_sel = '0; rd_sel = '0;
    dm_addr_sel = 1'b0; dm_we = 1'b0; a_sel = 1'b0; b_sel = 1'b0; rf_we = 1'b0;
    ret_en = 1'b0; se_b = '0; qt_b = '0; se_pc = '0; branch_taken = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;

    // Reset state
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_instr", ex_instr, 32'd0);
    check("rst_alu", 32'(ex_alu_op), 32'd0);
    check("rst_se_b", ex_se_b, 32'd0);
    check("rst_stall", 32'(hazard_stall), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Normal issue, one-cycle latency
    offer(1'b1, 32'h0022_0800, 5'h03, 1'b0, 2'b00);
    check("n1_ready", 32'(in_ready), 32'd1);
    tick();
    check("n1_valid", 32'(ex_valid), 32'd1);
    check("n1_instr", ex_instr, 32'h0022_0800);
    check("n1_alu", 32'(ex_alu_op), 32'h03);
    check("n1_se_b", ex_se_b, 32'h0022_F7FF);
    offer(1'b1, 32'h0064_1000, 5'h03, 1'b0, 2'b00);
    tick();
    check("n2_instr", ex_instr, 32'h0064_1000);
    check("n2_valid", 32'(ex_valid), 32'd1);
    offer(1'b0, 32'h0, 5'h00, 1'b0, 2'b00);
    tick();
    check("idle_bubble", 32'(ex_valid), 32'd0);

    // Load rd=5 then dependent rs=5
    offer(1'b1, 32'h00A1_0000, 5'h01, 1'b1, 2'b01);
    tick();
    offer(1'b1, 32'h00C5_0000, 5'h02, 1'b0, 2'b00);
    check("lu_stall", 32'(hazard_stall), 32'd1);
    check("lu_ready", 32'(in_ready), 32'd0);
    tick();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_hold", ex_instr, 32'h00A1_0000);
    check("lu_stall_drop", 32'(hazard_stall), 32'd0);
    check("lu_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("lu_dep_instr", ex_instr, 32'h00C5_0000);
    check("lu_dep_valid", 32'(ex_valid), 32'd1);

    // Load rd=5 then dependent through rt=5
    offer(1'b1, 32'h00A1_0000, 5'h01, 1'b1, 2'b01);
    tick();
    offer(1'b1, 32'h00C1_2800, 5'h02, 1'b0, 2'b00);
    check("lu_rt_stall", 32'(hazard_stall), 32'd1);
    tick(); tick();
    check("lu_rt_instr", ex_instr, 32'h00C1_2800);

    // Load rd=0 never stalls
    offer(1'b1, 32'h0001_0000, 5'h01, 1'b1, 2'b01);
    tick();
    offer(1'b1, 32'h00C0_0000, 5'h02, 1'b0, 2'b00);
    check("rd0_stall", 32'(hazard_stall), 32'd0);
    check("rd0_ready", 32'(in_ready), 32'd1);
    tick();
    check("rd0_instr", ex_instr, 32'h00C0_0000);
    check("rd0_valid", 32'(ex_valid), 32'd1);

    // Branch flush: two dropped, third issues
    offer(1'b0, 32'h0, 5'h00, 1'b0, 2'b00);
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    check("br_kill", 32'(ex_valid), 32'd0);
    offer(1'b1, 32'h0000_0B01, 5'h04, 1'b0, 2'b00);
    check("br_ready1", 32'(in_ready), 32'd1);
    tick();
    check("br_drop1", 32'(ex_valid), 32'd0);
    offer(1'b1, 32'h0000_0B02, 5'h04, 1'b0, 2'b00);
    check("br_ready2", 32'(in_ready), 32'd1);
    tick();
    check("br_drop2", 32'(ex_valid), 32'd0);
    offer(1'b1, 32'h0000_0B03, 5'h04, 1'b0, 2'b00);
    tick();
    check("br_issue_valid", 32'(ex_valid), 32'd1);
    check("br_issue_instr", ex_instr, 32'h0000_0B03);

    // Backpressure holds, then branch overrides the hold
    offer(1'b1, 32'h0022_1000, 5'h07, 1'b0, 2'b00);
    tick();
    ex_ready = 1'b0;
    offer(1'b1, 32'h0033_2000, 5'h08, 1'b0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_instr", ex_instr, 32'h0022_1000);
      check("bp_valid", 32'(ex_valid), 32'd1);
    end
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    check("bp_br_kill", 32'(ex_valid), 32'd0);
    ex_ready = 1'b1; #1;
    check("bp_br_flush_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_br_drop", 32'(ex_valid), 32'd0);

    // Reset in the middle of a flush returns straight to RUN
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_instr", ex_instr, 32'd0);
    offer(1'b1, 32'h0044_0000, 5'h09, 1'b0, 2'b00);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    tick();
    check("rst_mid_issue", ex_instr, 32'h0044_0000);
    check("rst_mid_valid", 32'(ex_valid), 32'd1);

`ifdef ID_EX_PERF_CNT_EN
    // Five stalls saturate a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      offer(1'b1, 32'h00A1_0000, 5'h01, 1'b1, 2'b01);
      tick();
      offer(1'b1, 32'h00C5_0000, 5'h02, 1'b0, 2'b00);
      tick(); tick();
    end
    check("perf_sat", 32'(perf_stall_cnt), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_rst", 32'(perf_stall_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
